// File: rtl/pll_cfg_shifter.sv
// Serial configuration loader for a PLL: shifts a word out MSB-first while
// reading SDO back, pulses LATCH, then releases RESET_N and waits for lock.
module pll_cfg_shifter #(
  parameter int CFG_BITS     = 27,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                busy,
  output logic                done,
  output logic                lock_err,
  output logic [CFG_BITS-1:0] rdata,
  output logic                pll_sclk,
  output logic                pll_sdi,
  output logic                pll_latch,
  output logic                pll_resetn,
  input  logic                pll_sdo,
  input  logic                pll_lock,
  output logic [2:0]          dbg_state
);

  // Handshake: start is a one-cycle request taken only in IDLE; busy rises on
  // the accepting edge and falls the cycle after the one-cycle done pulse.
  // Any start seen while busy is dropped, and cfg_data is sampled only then.

  localparam int BIT_W = $clog2(CFG_BITS + 1);
  localparam int TMO_W = 20;

  localparam logic [7:0]       PH_LAST  = 8'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SHIFT  = 3'd1,
    S_LATCH  = 3'd2,
    S_RELOCK = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          ph_q, ph_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CFG_BITS-1:0] sr_q, sr_d;
  logic [CFG_BITS-1:0] rdata_q, rdata_d;
  logic [1:0]          sync_q, sync_d;
  logic                lock_err_q, lock_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sclk_q, sclk_d;
  logic                sdi_q, sdi_d;
  logic                latch_q, latch_d;
  logic                resetn_q, resetn_d;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    bit_d      = bit_q;
    tmo_d      = tmo_q;
    sr_d       = sr_q;
    rdata_d    = rdata_q;
    lock_err_d = lock_err_q;
    sync_d     = 2'b00;
    sclk_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d       = cfg_data;
          lock_err_d = 1'b0;
          ph_d       = '0;
          bit_d      = '0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sclk_d = sclk_q;
        if (ph_q == PH_LAST) begin
          ph_d   = '0;
          sclk_d = ~sclk_q;
          // Falling SCLK edge: SDO is captured and the next SDI bit is presented.
          if (sclk_q) begin
            sr_d = {sr_q[CFG_BITS-2:0], pll_sdo};
            if (bit_q == BIT_LAST) begin
              rdata_d = {sr_q[CFG_BITS-2:0], pll_sdo};
              bit_d   = '0;
              state_d = S_LATCH;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      S_LATCH: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          tmo_d   = '0;
          state_d = S_RELOCK;
        end else begin
          ph_d = ph_q + 8'd1;
        end
      end

      S_RELOCK: begin
        // The synchronizer only runs here, so a lock level left over from
        // before the PLL was reset cannot end the wait early.
        sync_d = {sync_q[0], pll_lock};
        if (sync_q[1]) begin
          lock_err_d = 1'b0;
          state_d    = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          lock_err_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    latch_d  = (state_d == S_LATCH);
    resetn_d = (state_d == S_IDLE) || (state_d == S_RELOCK) || (state_d == S_DONE);
    sdi_d    = (state_d == S_SHIFT) ? sr_d[CFG_BITS-1] : 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ph_q       <= '0;
      bit_q      <= '0;
      tmo_q      <= '0;
      sr_q       <= '0;
      rdata_q    <= '0;
      sync_q     <= 2'b00;
      lock_err_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sdi_q      <= 1'b0;
      latch_q    <= 1'b0;
      resetn_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_q      <= bit_d;
      tmo_q      <= tmo_d;
      sr_q       <= sr_d;
      rdata_q    <= rdata_d;
      sync_q     <= sync_d;
      lock_err_q <= lock_err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      sdi_q      <= sdi_d;
      latch_q    <= latch_d;
      resetn_q   <= resetn_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign lock_err   = lock_err_q;
  assign rdata      = rdata_q;
  assign pll_sclk   = sclk_q;
  assign pll_sdi    = sdi_q;
  assign pll_latch  = latch_q;
  assign pll_resetn = resetn_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pll_cfg_shifter.sv
// Bench for pll_cfg_shifter: per-cycle expectations derived from the update
// timeline (shift, latch, relock wait, done) with randomized words and lock timing.
module tb_pll_cfg_shifter;

  localparam int B = 4;
  localparam int D = 2;
  localparam int T = 10;
  localparam int S = B * 2 * D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [B-1:0] cfg_data = '0;
  logic         busy, done, lock_err;
  logic [B-1:0] rdata;
  logic         pll_sclk, pll_sdi, pll_latch, pll_resetn;
  logic         pll_sdo = 1'b0;
  logic         pll_lock = 1'b0;
  logic [2:0]   dbg_state;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [B-1:0] exp_q[$];
  logic [B-1:0] last_rd = '0;
  logic         last_err = 1'b0;

  pll_cfg_shifter #(
    .CFG_BITS(B),
    .SCLK_DIV(D),
    .LOCK_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_data(cfg_data),
    .busy(busy),
    .done(done),
    .lock_err(lock_err),
    .rdata(rdata),
    .pll_sclk(pll_sclk),
    .pll_sdi(pll_sdi),
    .pll_latch(pll_latch),
    .pll_resetn(pll_resetn),
    .pll_sdo(pll_sdo),
    .pll_lock(pll_lock),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered at posedge+1 of an IDLE cycle; leaves at posedge+1 of the next IDLE cycle.
  // lock_at: RELOCK cycle index from which pll_lock is high (0 = tied high).
  task automatic run_update(input logic [B-1:0] cfg, input logic [B-1:0] sdo_w,
                            input int lock_at, input bit spam);
    int           dec, done_n;
    logic         exp_err;
    logic [B-1:0] exp_rd;
    logic [4:0]   exp_ctl;
    if (lock_at + 2 <= T) begin
      dec     = lock_at + 2;
      exp_err = 1'b0;
    end else begin
      dec     = T;
      exp_err = 1'b1;
    end
    done_n = S + D + dec + 1;
    exp_rd = last_rd;
    exp_q.push_back(sdo_w);

    start    = 1'b1;
    cfg_data = cfg;
    pll_lock = (lock_at == 0);
    pll_sdo  = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("idle_busy", 64'(busy), 64'(0));
    check_eq("idle_lock_err_hold", 64'(lock_err), 64'(last_err));
    check_eq("idle_rdata_hold", 64'(rdata), 64'(last_rd));
    @(posedge clk);
    #1;

    for (int n = 0; n <= done_n + 1; n++) begin
      start = spam && (n <= done_n);
      if (spam) cfg_data = B'($urandom);
      if (n < S) pll_sdo = sdo_w[B - 1 - n / (2 * D)];
      else pll_sdo = 1'($urandom_range(0, 1));
      if (n >= S + D) pll_lock = ((n - (S + D)) >= lock_at);
      else pll_lock = (lock_at == 0);
      if (n == S) exp_rd = exp_q.pop_front();

      @(negedge clk);
      exp_ctl = {n <= done_n, n == done_n, (n < S) && ((n % (2 * D)) >= D),
                 (n >= S) && (n < S + D), n >= S + D};
      check_eq("ctl_busy_done_sclk_latch_resetn",
               64'({busy, done, pll_sclk, pll_latch, pll_resetn}), 64'(exp_ctl));
      if (n < S) check_eq("sdi", 64'(pll_sdi), 64'(cfg[B - 1 - n / (2 * D)]));
      check_eq("rdata", 64'(rdata), 64'(exp_rd));
      check_eq("lock_err", 64'(lock_err), 64'((n >= done_n) ? exp_err : 1'b0));
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    last_rd  = exp_rd;
    last_err = exp_err;
  endtask

  // Reset lands in the 5th SHIFT cycle; the next update starts on the first cycle after release.
  task automatic abort_test(input logic [B-1:0] cfg);
    start    = 1'b1;
    cfg_data = cfg;
    pll_lock = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
    end
    check_eq("abort_pre_busy", 64'(busy), 64'(1));
    check_eq("abort_pre_sdi", 64'(pll_sdi), 64'(cfg[B - 2]));
    rst = 1'b1;
    #1;
    check_eq("abort_outputs", 64'({busy, done, lock_err, pll_sclk, pll_sdi, pll_latch, pll_resetn}),
             64'(0));
    check_eq("abort_rdata", 64'(rdata), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("abort_no_done", 64'({busy, done}), 64'(0));
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    last_rd  = '0;
    last_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs", 64'({busy, done, lock_err, pll_sclk, pll_sdi, pll_latch, pll_resetn}),
             64'(0));
    check_eq("reset_rdata", 64'(rdata), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("resetn_before_first_edge", 64'(pll_resetn), 64'(0));
    @(negedge clk);
    check_eq("resetn_after_first_edge", 64'({busy, pll_resetn}), 64'(1));
    @(posedge clk);
    #1;

    run_update(4'b1011, 4'b0110, 0, 1'b0);
    run_update(4'b0101, 4'b1001, 100, 1'b0);
    run_update(4'b1100, 4'b0011, T - 2, 1'b0);
    run_update(4'b0011, 4'b1110, T - 1, 1'b0);
    run_update(4'b1001, 4'b0101, 3, 1'b1);
    abort_test(4'b0110);
    run_update(4'b1110, 4'b1011, 1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_update(B'($urandom), B'($urandom), int'($urandom_range(0, T + 4)),
                 ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
